// File: rtl/seg_pkg.sv
// Shared constants, index-width helper and slot-phase type for the 7-segment scanner.
package seg_pkg;

  localparam int unsigned MAX_DIGITS = 8;

  // Anode enables and decimal point are active-low.
  localparam logic [MAX_DIGITS-1:0] ALL_OFF = '1;
  localparam logic                  SEL_ON  = 1'b0;
  localparam logic                  DP_OFF  = 1'b1;

  typedef enum logic {
    PH_BLANK,
    PH_LIT
  } phase_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_scan_if.sv
// Host-side load port and display-side scan outputs of the seg_scan block.
interface seg_scan_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic [3:0]              digit_nibble;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic                    dp_n;
  logic                    frame_done;
  logic                    load_ack;

  modport master (
    output value_in, dp_in, load,
    input  digit_nibble, digit_sel, dp_n, frame_done, load_ack
  );

  modport slave (
    input  value_in, dp_in, load,
    output digit_nibble, digit_sel, dp_n, frame_done, load_ack
  );
endinterface

// File: rtl/seg_tick_gen.sv
// Slot prescaler: counts 0..REFRESH_DIV-1 and flags the last cycle of each slot.
module seg_tick_gen
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] cnt,
  output logic             slot_end
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    slot_end = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed common-anode 7-segment scanner with frame-aligned word commit,
// inter-digit blanking and optional leading-zero suppression.
module seg_scan
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter int unsigned BLANK_LZ     = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  seg_scan_if.slave      bus
);

  localparam int unsigned IDX_W = idx_width(NUM_DIGITS);
  localparam int unsigned CNT_W = idx_width(REFRESH_DIV);
  localparam int unsigned W_W   = 4 * NUM_DIGITS;

  logic [CNT_W-1:0] cnt;
  logic             slot_end;

  seg_tick_gen #(
    .REFRESH_DIV (REFRESH_DIV),
    .CNT_W       (CNT_W)
  ) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .cnt      (cnt),
    .slot_end (slot_end)
  );

  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [W_W-1:0]        pend_q, pend_d, disp_q, disp_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic [3:0]            nib_q, nib_d;
  logic                  dp_n_q, dp_n_d;
  logic                  fd_q, fd_d;
  logic                  ack_q, ack_d;

  logic                  wrap, commit, upper_nz;
  logic [NUM_DIGITS-1:0] lz_sup;
  phase_e                phase;

  always_comb begin
    phase  = (cnt < CNT_W'(BLANK_CYCLES)) ? PH_BLANK : PH_LIT;
    wrap   = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));
    commit = wrap && pend_vld_q;

    idx_d = idx_q;
    if (slot_end) idx_d = wrap ? '0 : idx_q + 1'b1;

    // Commit reads the pending word as it stood before this cycle; a load in the
    // same cycle refills pending and keeps it valid for the next wrap.
    pend_d     = pend_q;
    pend_dp_d  = pend_dp_q;
    pend_vld_d = pend_vld_q;
    disp_d     = disp_q;
    disp_dp_d  = disp_dp_q;
    if (commit) begin
      disp_d     = pend_q;
      disp_dp_d  = pend_dp_q;
      pend_vld_d = 1'b0;
    end
    if (bus.load) begin
      pend_d     = bus.value_in;
      pend_dp_d  = bus.dp_in;
      pend_vld_d = 1'b1;
    end

    // Digit i>0 is a leading zero when it and every higher nibble are zero.
    upper_nz = 1'b0;
    lz_sup   = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      upper_nz = upper_nz || (disp_q[4*(NUM_DIGITS-1-k) +: 4] != 4'h0);
      lz_sup[NUM_DIGITS-1-k] = (k != NUM_DIGITS - 1) && !upper_nz;
    end

    sel_d  = ALL_OFF[NUM_DIGITS-1:0];
    nib_d  = '0;
    dp_n_d = DP_OFF;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_d = disp_q[4*i +: 4];
        if (phase == PH_LIT && !(BLANK_LZ != 0 && lz_sup[i])) begin
          sel_d[i] = SEL_ON;
          dp_n_d   = ~disp_dp_q[i];
        end
      end
    end

    fd_d  = wrap;
    ack_d = commit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      pend_q     <= '0;
      pend_dp_q  <= '0;
      pend_vld_q <= 1'b0;
      disp_q     <= '0;
      disp_dp_q  <= '0;
      sel_q      <= ALL_OFF[NUM_DIGITS-1:0];
      nib_q      <= '0;
      dp_n_q     <= DP_OFF;
      fd_q       <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      pend_dp_q  <= pend_dp_d;
      pend_vld_q <= pend_vld_d;
      disp_q     <= disp_d;
      disp_dp_q  <= disp_dp_d;
      sel_q      <= sel_d;
      nib_q      <= nib_d;
      dp_n_q     <= dp_n_d;
      fd_q       <= fd_d;
      ack_q      <= ack_d;
    end
  end

  assign bus.digit_sel    = sel_q;
  assign bus.digit_nibble = nib_q;
  assign bus.dp_n         = dp_n_q;
  assign bus.frame_done   = fd_q;
  assign bus.load_ack     = ack_q;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan (4 digits, 4-cycle slots, 1 blank cycle); a second
// instance with leading-zero suppression disabled shadows the same stimulus.
module tb_seg_scan;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  seg_scan_if #(.NUM_DIGITS(4)) bus  ();
  seg_scan_if #(.NUM_DIGITS(4)) bus0 ();

  assign bus0.value_in = bus.value_in;
  assign bus0.dp_in    = bus.dp_in;
  assign bus0.load     = bus.load;

  seg_scan #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .BLANK_LZ(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  seg_scan #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .BLANK_LZ(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    bus.value_in = v;
    bus.dp_in    = d;
    bus.load     = 1'b1;
    tick();
    bus.load     = 1'b0;
  endtask

  task automatic wait_fd(input string tag, input logic exp_ack);
    int unsigned n = 0;
    do begin
      tick();
      n++;
    end while (bus.frame_done !== 1'b1 && n < 40);
    chk({tag, "_fd"}, 32'(bus.frame_done), 32'd1);
    chk({tag, "_ack"}, 32'(bus.load_ack), 32'(exp_ack));
  endtask

  task automatic rel_check(input string tag);
    rst_n = 1'b1;
    tick();
    chk({tag, "_blank_sel"}, 32'(bus.digit_sel), 32'hF);
    chk({tag, "_blank_nib"}, 32'(bus.digit_nibble), 32'h0);
    tick();
    chk({tag, "_d0_sel"}, 32'(bus.digit_sel), 32'hE);
    chk({tag, "_d0_nib"}, 32'(bus.digit_nibble), 32'h0);
    chk({tag, "_d0_dp"}, 32'(bus.dp_n), 32'h1);
    chk({tag, "_d0_fd"}, 32'(bus.frame_done), 32'h0);
  endtask

  // Checks one full frame starting right after a frame_done sample.
  task automatic check_frame(input string tag, input logic [15:0] val, input logic [3:0] dp,
                             input logic [3:0] lit, input logic ack_end);
    logic [3:0] exp_sel, exp_sel0;
    logic       exp_dp, last;
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        exp_sel  = 4'hF;
        exp_sel0 = 4'hF;
        exp_dp   = 1'b1;
        if (c != 0) begin
          exp_sel0[s] = 1'b0;
          if (lit[s]) begin
            exp_sel[s] = 1'b0;
            exp_dp     = ~dp[s];
          end
        end
        last = (s == 3 && c == 3);
        chk({tag, "_sel"},  32'(bus.digit_sel),    32'(exp_sel));
        chk({tag, "_sel0"}, 32'(bus0.digit_sel),   32'(exp_sel0));
        chk({tag, "_dp"},   32'(bus.dp_n),         32'(exp_dp));
        chk({tag, "_nib"},  32'(bus.digit_nibble), 32'(val[4*s +: 4]));
        chk({tag, "_fd"},   32'(bus.frame_done),   32'(last));
        chk({tag, "_ack"},  32'(bus.load_ack),     32'(last ? ack_end : 1'b0));
      end
    end
  endtask

  initial begin
    int last_fd;
    rst_n        = 1'b1;
    bus.value_in = '0;
    bus.dp_in    = '0;
    bus.load     = 1'b0;

    // Asynchronous assertion before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_sel", 32'(bus.digit_sel), 32'hF);
    chk("rst_nib", 32'(bus.digit_nibble), 32'h0);
    chk("rst_dp",  32'(bus.dp_n), 32'h1);
    chk("rst_fd",  32'(bus.frame_done), 32'h0);
    chk("rst_ack", 32'(bus.load_ack), 32'h0);
    tick();
    tick();
    chk("rst_hold_sel", 32'(bus.digit_sel), 32'hF);
    rel_check("rel1");

    do_load(16'h1234, 4'b0100);
    wait_fd("w1234", 1'b1);
    check_frame("f1234", 16'h1234, 4'b0100, 4'b1111, 1'b0);

    do_load(16'h0050, 4'b0000);
    wait_fd("w0050", 1'b1);
    check_frame("f0050", 16'h0050, 4'b0000, 4'b0011, 1'b0);

    do_load(16'h0000, 4'b0000);
    wait_fd("w0000", 1'b1);
    check_frame("f0000", 16'h0000, 4'b0000, 4'b0001, 1'b0);

    do_load(16'hAAAA, 4'b1111);
    tick();
    tick();
    do_load(16'hBBBB, 4'b0001);
    wait_fd("wlast", 1'b1);
    check_frame("flast", 16'hBBBB, 4'b0001, 4'b1111, 1'b0);

    // 5555 pending, then 7777 lands exactly on the edge that commits 5555.
    do_load(16'h5555, 4'b0000);
    repeat (14) tick();
    do_load(16'h7777, 4'b1000);
    chk("coll_fd",  32'(bus.frame_done), 32'h1);
    chk("coll_ack", 32'(bus.load_ack), 32'h1);
    check_frame("f5555", 16'h5555, 4'b0000, 4'b1111, 1'b1);
    check_frame("f7777", 16'h7777, 4'b1000, 4'b1111, 1'b0);

    // Reset between edges while frame_done, load_ack and an anode are all active.
    do_load(16'h1234, 4'b0100);
    wait_fd("wmid", 1'b1);
    chk("mid_pre_sel", 32'(bus.digit_sel), 32'h7);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_sel", 32'(bus.digit_sel), 32'hF);
    chk("mid_dp",  32'(bus.dp_n), 32'h1);
    chk("mid_fd",  32'(bus.frame_done), 32'h0);
    chk("mid_ack", 32'(bus.load_ack), 32'h0);
    chk("mid_nib", 32'(bus.digit_nibble), 32'h0);
    tick();
    chk("mid_hold_sel", 32'(bus.digit_sel), 32'hF);
    rel_check("rel2");
    wait_fd("wnopend", 1'b0);

    last_fd = -1;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      bus.value_in = 16'($urandom);
      bus.dp_in    = 4'($urandom);
      bus.load     = ($urandom_range(0, 7) == 0);
      tick();
      chk("onehot",  32'($countones(~bus.digit_sel) <= 1), 32'd1);
      chk("onehot0", 32'($countones(~bus0.digit_sel) <= 1), 32'd1);
      if (bus.frame_done === 1'b1) begin
        if (last_fd >= 0) chk("fd_period", 32'(cyc - last_fd), 32'd16);
        last_fd = cyc;
      end
    end
    bus.load = 1'b0;
    chk("fd_seen", 32'(last_fd >= 0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
Name: seg_scan

Overview:
- Time-multiplexed scanner for a common-anode multi-digit 7-segment display.
- Sits directly upstream of the hex-to-segment decoder. Each slot it presents one 4-bit nibble on digit_nibble, which feeds the decoder input, and drives the active-low digit enables.
- Captures a new display word on a load strobe. The new word takes effect only at a frame boundary, so a frame never shows a torn value.
- Provides inter-digit blanking against ghosting and optional leading-zero suppression.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8).
- REFRESH_DIV, 50000, clock cycles per digit slot (>= BLANK_CYCLES+1).
- BLANK_CYCLES, 500, cycles at the start of each slot with all digits off.
- BLANK_LZ, 1, 1 = suppress leading zeros (digit 0 is never suppressed).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- value_in  in  4*NUM_DIGITS  hex word; digit i = value_in[4i+3:4i].
- dp_in  in  NUM_DIGITS  decimal-point request per digit, active-high.
- load  in  1  one-cycle strobe; captures value_in/dp_in into the pending register.
- digit_nibble  out  4  nibble of the active digit; goes to the decoder input.
- digit_sel  out  NUM_DIGITS  anode enables, active-low, at most one bit low.
- dp_n  out  1  decimal point, active-low.
- frame_done  out  1  one-cycle pulse at each frame wrap.
- load_ack  out  1  one-cycle pulse when a pending word is committed to display.

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous, active-low.
- Reset values: prescaler cnt=0, digit index idx=0, display/pending registers=0, pending_valid=0. Outputs: digit_sel=all 1, digit_nibble=0, dp_n=1, frame_done=0, load_ack=0. Outputs take these values immediately on rst_n low, without waiting for a clock edge, including mid-frame.
- Prescaler:
  - cnt increments every cycle.
  - At cnt==REFRESH_DIV-1 (slot end), cnt<=0 and idx<=idx+1, wrapping NUM_DIGITS-1 -> 0.
- Frame wrap (slot end with idx==NUM_DIGITS-1):
  - frame_done pulses in the following cycle.
  - If pending_valid=1: display<=pending, pending_valid<=0, and load_ack pulses in the same cycle as frame_done.
- Load:
  - When load=1, pending<=value_in, dp pending<=dp_in, pending_valid<=1.
  - Multiple loads before a wrap: last one wins; exactly one load_ack.
  - Load in the same cycle as a wrap commit: the commit uses the pending content from before this cycle. The new word is written to pending and pending_valid stays 1, so it commits at the next wrap.
- Outputs are registered, one-cycle latency from (cnt, idx, display).
  - Blank: if cnt < BLANK_CYCLES, digit_sel=all 1 and dp_n=1.
  - Otherwise digit_sel[idx]=0, all other bits 1, digit_nibble=display nibble idx, dp_n=~dp[idx].
- Leading-zero suppression (BLANK_LZ=1): digit i>0 is suppressed when display nibbles i..NUM_DIGITS-1 are all 0. In a suppressed slot, digit_sel=all 1 and dp_n=1. digit_nibble still carries the nibble.
- No lock-up states: idx is always in 0..NUM_DIGITS-1. The wrap is explicit, not a power-of-two overflow.

Decomposition:
- Package seg_pkg holds:
  - MAX_DIGITS=8;
  - the digit-index width function (clog2 of NUM_DIGITS);
  - the active-low constants ALL_OFF and SEL_ON.
- One sub-module, seg_tick_gen: REFRESH_DIV prescaler that outputs cnt and slot_end.
- The scanner holds idx, the pending/display registers, blanking and output registers.
- The hex-to-segment decoder is instantiated by the parent, not inside seg_scan.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, BLANK_LZ=1 unless stated):
- Async reset: rst_n low between clock edges, mid-slot -> same instant digit_sel=4'b1111, dp_n=1, frame_done=0, load_ack=0. After release: first slot shows 1 blank cycle, then digit_sel=4'b1110.
- Load 16'h1234, dp_in=4'b0100 -> load_ack with frame_done at next wrap. Next frame, per slot: 1 cycle sel=1111, then 3 cycles of:
  - sel=1110 with nibble 4, dp_n=1;
  - sel=1101 with nibble 3, dp_n=1;
  - sel=1011 with nibble 2, dp_n=0;
  - sel=0111 with nibble 1, dp_n=1.
- LZ: load 16'h0050 -> digits 3,2 slots keep sel=1111; digit1 sel=1101 nibble 5; digit0 sel=1110 nibble 0. Load 16'h0000 -> only digit0 lit. With BLANK_LZ=0, all four digits light.
- Last-wins: load 16'hAAAA then 16'hBBBB in the same frame -> one load_ack; next frame shows B on all digits; A never displayed.
- Collision: load 16'h5555 committed; load 16'h7777 exactly on the wrap-commit cycle -> that frame shows 5555 and load_ack pulses. At the following wrap a second load_ack pulses and 7777 is displayed.
- Invariant check over 10000 random cycles with random loads: popcount(~digit_sel)<=1 every cycle; frame_done period = 16 cycles.
